// File: rtl/idex_skid_reg.sv
// idex_skid_reg: parametrised ID/EX pipeline register with valid/ready flow control.
//
// A two-entry skid buffer sits between decode and execute: the main entry drives
// the outputs and the skid entry absorbs one item when EX stalls. Because
// in_ready_o depends only on registered state, there is no combinational path
// from the EX side back to ID. Flush kills all held entries. A saturating counter
// records the cycles in which EX was ready but received a bubble.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   flush_i        synchronous kill of all held entries
//   in_valid_i     upstream offers payload
//   in_ready_o     block can accept payload this cycle
//   in_ctrl_i      control payload  [CTRL_W]
//   in_data_i      data payload     [DATA_W]
//   out_valid_o    payload presented to EX
//   out_ready_i    EX consumes payload this cycle
//   out_ctrl_o     control to EX, BUBBLE_CTRL when out_valid_o=0
//   out_data_o     data to EX, holds its last value when invalid
//   bubble_count_o saturating count of bubble cycles seen by a ready EX
//   bubble_clr_i   synchronous clear of bubble_count_o

module idex_skid_reg #(
  parameter int unsigned          DATA_W      = 32,
  parameter int unsigned          CTRL_W      = 16,
  parameter logic [CTRL_W-1:0]    BUBBLE_CTRL = '0,
  parameter int unsigned          CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  bubble_count_o,
  input  logic              bubble_clr_i
);

  // Occupancy is encoded directly by {m_valid, s_valid}.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StBad   = 2'b01,
    StOne   = 2'b10,
    StTwo   = 2'b11
  } state_e;

  logic              m_valid_q, m_valid_d;
  logic              s_valid_q, s_valid_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  state_e state;
  logic   accept;
  logic   consume;

  assign state   = state_e'({m_valid_q, s_valid_q});
  assign accept  = in_valid_i & in_ready_o;
  assign consume = m_valid_q & out_ready_i;

  assign in_ready_o     = ~s_valid_q;
  assign out_valid_o    = m_valid_q;
  assign out_ctrl_o     = m_valid_q ? m_ctrl_q : BUBBLE_CTRL;
  assign out_data_o     = m_data_q;
  assign bubble_count_o = cnt_q;

  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_ctrl_d  = m_ctrl_q;
    s_ctrl_d  = s_ctrl_q;
    m_data_d  = m_data_q;
    s_data_d  = s_data_q;

    if (flush_i) begin
      // Payload registers are left alone; only the valid bits are killed.
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else begin
      unique case (state)
        StEmpty: begin
          if (accept) begin
            m_valid_d = 1'b1;
            m_ctrl_d  = in_ctrl_i;
            m_data_d  = in_data_i;
          end
        end
        StOne: begin
          if (accept && consume) begin
            m_ctrl_d = in_ctrl_i;
            m_data_d = in_data_i;
          end else if (accept) begin
            s_valid_d = 1'b1;
            s_ctrl_d  = in_ctrl_i;
            s_data_d  = in_data_i;
          end else if (consume) begin
            m_valid_d = 1'b0;
          end
        end
        StTwo: begin
          // in_ready_o is low here, so only the drain direction can move.
          if (consume) begin
            s_valid_d = 1'b0;
            m_ctrl_d  = s_ctrl_q;
            m_data_d  = s_data_q;
          end
        end
        default: begin
          m_valid_d = m_valid_q;
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bubble_clr_i) begin
      cnt_d = '0;
    end else if (out_ready_i && !m_valid_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_ctrl_q  <= BUBBLE_CTRL;
      s_ctrl_q  <= BUBBLE_CTRL;
      m_data_q  <= '0;
      s_data_q  <= '0;
      cnt_q     <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_ctrl_q  <= m_ctrl_d;
      s_ctrl_q  <= s_ctrl_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
      cnt_q     <= cnt_d;
    end
  end

  // Skid content is always younger than main, so skid valid without main is illegal.
  skid_without_main_a : assert property (@(posedge clk_i) disable iff (rst_i)
    !(!m_valid_q && s_valid_q))
    else $error("skid entry valid while main entry empty");

endmodule

// File: tb/tb_idex_skid_reg.sv
module tb_idex_skid_reg;

  localparam int unsigned       DW   = 32;
  localparam int unsigned       CW   = 8;
  localparam int unsigned       CNTW = 3;
  localparam int unsigned       CMAX = 7;
  localparam logic [CW-1:0]     BUB  = 8'h5A;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [CW-1:0] in_ctrl_i;
  logic [DW-1:0] in_data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [CW-1:0] out_ctrl_o;
  logic [DW-1:0] out_data_o;
  logic [CNTW-1:0] bubble_count_o;
  logic          bubble_clr_i;

  idex_skid_reg #(
    .DATA_W     (DW),
    .CTRL_W     (CW),
    .BUBBLE_CTRL(BUB),
    .CNT_W      (CNTW)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_ctrl_i     (in_ctrl_i),
    .in_data_i     (in_data_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_ctrl_o    (out_ctrl_o),
    .out_data_o    (out_data_o),
    .bubble_count_o(bubble_count_o),
    .bubble_clr_i  (bubble_clr_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a FIFO of held items (at most two), the data last seen at
  // the head, and the bubble counter.
  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } item_t;

  item_t         q[$];
  logic [DW-1:0] last_d;
  int unsigned   cnt;

  task automatic model_reset();
    q.delete();
    last_d = '0;
    cnt    = 0;
  endtask

  task automatic model_step();
    bit    cons;
    bit    acc;
    item_t it;
    if (bubble_clr_i) cnt = 0;
    else if (out_ready_i && q.size() == 0 && cnt < CMAX) cnt++;
    if (flush_i) begin
      q.delete();
    end else begin
      cons = (q.size() > 0) && out_ready_i;
      acc  = in_valid_i && (q.size() < 2);
      if (cons) void'(q.pop_front());
      if (acc) begin
        it.c = in_ctrl_i;
        it.d = in_data_i;
        q.push_back(it);
      end
    end
    if (q.size() > 0) last_d = q[0].d;
  endtask

  task automatic check_model();
    bit v;
    v = q.size() > 0;
    chk("out_valid", out_valid_o, v);
    chk("in_ready", in_ready_o, q.size() < 2);
    chk("out_ctrl", out_ctrl_o, v ? q[0].c : BUB);
    chk("out_data", out_data_o, v ? q[0].d : last_d);
    chk("bubble_count", bubble_count_o, cnt);
  endtask

  // Called at a negedge: drive, let one rising edge pass, update model, check.
  task automatic step(input logic iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input logic ordy, input logic fl, input logic clr);
    in_valid_i   = iv;
    in_ctrl_i    = c;
    in_data_i    = d;
    out_ready_i  = ordy;
    flush_i      = fl;
    bubble_clr_i = clr;
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
    check_model();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
    check_model();
  endtask

  initial begin
    rst_i        = 1'b1;
    flush_i      = 1'b0;
    in_valid_i   = 1'b0;
    in_ctrl_i    = '0;
    in_data_i    = '0;
    out_ready_i  = 1'b0;
    bubble_clr_i = 1'b0;
    do_reset();
    chk("reset_out_valid", out_valid_o, 0);
    chk("reset_in_ready", in_ready_o, 1);
    chk("reset_out_ctrl", out_ctrl_o, BUB);

    // Test 1: async reset mid-cycle while holding two items and a nonzero count.
    step(0, 8'h00, 32'h0, 1, 0, 0);
    step(0, 8'h00, 32'h0, 1, 0, 0);
    step(1, 8'h11, 32'hAAAA, 0, 0, 0);
    step(1, 8'h22, 32'hBBBB, 0, 0, 0);
    chk("two_in_ready", in_ready_o, 0);
    in_valid_i = 1'b1;
    #2 rst_i = 1'b1;
    #1;
    chk("async_out_valid", out_valid_o, 0);
    chk("async_in_ready", in_ready_o, 1);
    chk("async_out_ctrl", out_ctrl_o, BUB);
    chk("async_out_data", out_data_o, 0);
    chk("async_bubble_count", bubble_count_o, 0);
    out_ready_i = 1'b1;
    @(negedge clk_i);
    chk("rst_no_accept", out_valid_o, 0);
    chk("rst_no_count", bubble_count_o, 0);
    rst_i      = 1'b0;
    in_valid_i = 1'b0;
    model_reset();
    check_model();

    // Test 2: streaming, one cycle from accept to output, skid never used.
    for (int i = 1; i <= 8; i++) begin
      step(1, 8'(i), 32'(i), 1, 0, 0);
      chk("stream_valid", out_valid_o, 1);
      chk("stream_data", out_data_o, i);
      chk("stream_in_ready", in_ready_o, 1);
    end
    step(0, 8'h00, 32'h0, 1, 0, 0);

    // Test 3: backpressure, A and B fill, C held off, then drained in order.
    step(1, 8'h0A, 32'hA, 0, 0, 0);
    step(1, 8'h0B, 32'hB, 0, 0, 0);
    chk("bp_in_ready", in_ready_o, 0);
    step(1, 8'h0C, 32'hC, 0, 0, 0);
    chk("bp_hold_A", out_data_o, 32'hA);
    step(1, 8'h0C, 32'hC, 1, 0, 0);
    chk("bp_out_B", out_data_o, 32'hB);
    step(1, 8'h0C, 32'hC, 1, 0, 0);
    chk("bp_out_C", out_data_o, 32'hC);
    chk("bp_ctrl_C", out_ctrl_o, 8'h0C);
    step(0, 8'h00, 32'h0, 1, 0, 0);
    chk("bp_drained", out_valid_o, 0);

    // Test 4: flush in TWO with C offered; nothing survives.
    step(1, 8'h1A, 32'h1A, 0, 0, 0);
    step(1, 8'h1B, 32'h1B, 0, 0, 0);
    step(1, 8'h1C, 32'h1C, 0, 1, 0);
    chk("flush_valid", out_valid_o, 0);
    chk("flush_ctrl", out_ctrl_o, BUB);
    chk("flush_in_ready", in_ready_o, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 8'h00, 32'h0, 1, 0, 0);
      chk("flush_stays_empty", out_valid_o, 0);
    end

    // Test 5: bubble counter saturates at 7, clear beats increment.
    step(0, 8'h00, 32'h0, 0, 0, 1);
    chk("cnt_cleared", bubble_count_o, 0);
    for (int i = 1; i <= 10; i++) begin
      step(0, 8'h00, 32'h0, 1, 0, 0);
      chk("cnt_sat", bubble_count_o, (i > 7) ? 7 : i);
    end
    step(0, 8'h00, 32'h0, 1, 0, 1);
    chk("cnt_clr_wins", bubble_count_o, 0);

    // Test 6: random traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 99) < 60), 8'($urandom), $urandom,
           ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 5),
           ($urandom_range(0, 99) < 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
